// File: rtl/valid_move_checker.sv
// -----------------------------------------------------------------------------
// valid_move_checker
//
// Purpose
//   Converts a sprite's display-pixel anchor position into a maze cell index
//   and reports which of the four neighbouring cells are open for movement.
//   Sits between the player/ghost movement FSM and the maze ROM.
//
//   Two-stage pipeline, inputs sampled every cycle, no handshake:
//     stage 1 : pixel -> (col,row) cell index plus an in-grid flag
//     stage 2 : ROM lookup of rows row-1,row,row+1 -> registered valid_moves
//   The result for an input appears on valid_moves two clocks after it is
//   presented.
//
// Ports
//   clk          in   1   system clock, all logic on the rising edge
//   rst          in   1   asynchronous, active-high reset
//   curr_pos_x   in   11  sprite anchor display x (pixels)
//   curr_pos_y   in   10  sprite anchor display y (pixels)
//   valid_moves  out  4   [3]=left [2]=down [1]=up [0]=right; 1 = move allowed
//
// Parameters
//   ORIGIN_X / ORIGIN_Y  display coordinates of the maze's top-left corner
//   TILE_LOG2            log2 of the tile size in pixels
//   CENTER_OFS           offset from the tile edge to the sprite anchor
//   GRID_COLS/GRID_ROWS  maze size in cells
//   MAZE                 maze contents, bit (row*GRID_COLS + col), 1 = path,
//                        0 = wall. Layout is one word per row, bit c =
//                        column c, packed row 0 first. The default is the
//                        bring-up maze: all path except walls at (col 8,
//                        row 7) and (col 1, row 24). Contents are fixed at
//                        elaboration, so the ROM has no write port.
//
// Configuration
//   CENTER_ALIGN_EN  when defined, a position reports moves only if the
//                    anchor sits exactly on a tile anchor in both axes
//                    (turns only at tile centres); otherwise valid_moves=0.
//                    When undefined, off-centre positions use the floor
//                    cell index.
//
// Neighbours that fall outside the grid count as wall; there is no tunnel or
// wrap-around. The sprite's own cell is not checked.
// -----------------------------------------------------------------------------

package valid_move_checker_pkg;

  // Largest maze the built-in default image generator can describe.
  localparam int MAZE_BITS_MAX = 1024;

  // Bring-up maze: every cell is path except two interior walls.
  function automatic logic [MAZE_BITS_MAX-1:0] test_maze(input int rows,
                                                          input int cols);
    logic [MAZE_BITS_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < MAZE_BITS_MAX; i++) begin
      if (i < rows * cols) m[i] = 1'b1;
    end
    if (7 < rows && 8 < cols)  m[7 * cols + 8]  = 1'b0;
    if (24 < rows && 1 < cols) m[24 * cols + 1] = 1'b0;
    return m;
  endfunction

endpackage

module valid_move_checker #(
  parameter int ORIGIN_X   = 336,
  parameter int ORIGIN_Y   = 27,
  parameter int TILE_LOG2  = 4,
  parameter int CENTER_OFS = 7,
  parameter int GRID_COLS  = 28,
  parameter int GRID_ROWS  = 31,
  parameter logic [GRID_ROWS*GRID_COLS-1:0] MAZE =
    (GRID_ROWS*GRID_COLS)'(valid_move_checker_pkg::test_maze(GRID_ROWS, GRID_COLS))
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] curr_pos_x,
  input  logic [9:0]  curr_pos_y,
  output logic [3:0]  valid_moves
);

  // Offsets are computed at 12 bits signed so positions left of / above the
  // maze go negative instead of wrapping.
  localparam int CW = 12;
  // Width of a cell index taken from the top bits of a 12-bit offset.
  localparam int IW = CW - TILE_LOG2;

  localparam logic signed [CW-1:0] X_BIAS = CW'(ORIGIN_X + CENTER_OFS);
  localparam logic signed [CW-1:0] Y_BIAS = CW'(ORIGIN_Y + CENTER_OFS);
  localparam logic [IW-1:0]        COLS_W = IW'(GRID_COLS);
  localparam logic [IW-1:0]        ROWS_W = IW'(GRID_ROWS);

  // ---------------------------------------------------------------------------
  // Stage 1: pixel -> cell
  // ---------------------------------------------------------------------------
  logic signed [CW-1:0] rx;
  logic signed [CW-1:0] ry;
  logic [IW-1:0]        col_d;
  logic [IW-1:0]        row_d;
  logic                 in_grid_d;

  assign rx = $signed({1'b0, curr_pos_x}) - X_BIAS;
  assign ry = $signed({2'b00, curr_pos_y}) - Y_BIAS;

  // The shift result is only trusted when the offset is non-negative, so a
  // plain bit slice is enough; negative offsets are filtered by in_grid_d.
  assign col_d = rx[CW-1:TILE_LOG2];
  assign row_d = ry[CW-1:TILE_LOG2];

`ifdef CENTER_ALIGN_EN
  // Anchor must sit exactly on a tile anchor in both axes.
  logic on_anchor;
  assign on_anchor = (rx[TILE_LOG2-1:0] == '0) && (ry[TILE_LOG2-1:0] == '0);
`else
  // The sub-tile fraction only matters for centre alignment.
  logic unused_frac;
  logic on_anchor;
  assign unused_frac = ^{rx[TILE_LOG2-1:0], ry[TILE_LOG2-1:0]};
  assign on_anchor   = 1'b1;
`endif

  assign in_grid_d = !rx[CW-1] && !ry[CW-1] &&
                     (col_d < COLS_W) && (row_d < ROWS_W) && on_anchor;

  logic [IW-1:0] col_q;
  logic [IW-1:0] row_q;
  logic          in_grid_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      in_grid_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      in_grid_q <= in_grid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: maze lookup
  // ---------------------------------------------------------------------------
  logic [GRID_COLS-1:0] row_up;
  logic [GRID_COLS-1:0] row_mid;
  logic [GRID_COLS-1:0] row_dn;
  logic                 open_left;
  logic                 open_right;
  logic                 open_up;
  logic                 open_down;
  logic [3:0]           moves_d;

  // Rows and columns are selected by comparing against every constant index.
  // An index that lands outside the grid (row -1, row GRID_ROWS, col -1,
  // col GRID_COLS) simply matches nothing and the neighbour stays a wall,
  // which gives the no-wrap border behaviour without separate edge checks.
  // NOTE: every output of this block gets a default first so no path through
  // it leaves a value unassigned (which would infer a latch).
  always_comb begin
    row_up     = '0;
    row_mid    = '0;
    row_dn     = '0;
    open_left  = 1'b0;
    open_right = 1'b0;
    open_up    = 1'b0;
    open_down  = 1'b0;

    for (int r = 0; r < GRID_ROWS; r++) begin
      if (r == int'(row_q) - 1) row_up  = MAZE[r*GRID_COLS +: GRID_COLS];
      if (r == int'(row_q))     row_mid = MAZE[r*GRID_COLS +: GRID_COLS];
      if (r == int'(row_q) + 1) row_dn  = MAZE[r*GRID_COLS +: GRID_COLS];
    end

    for (int c = 0; c < GRID_COLS; c++) begin
      if (c == int'(col_q) - 1) open_left  = row_mid[c];
      if (c == int'(col_q) + 1) open_right = row_mid[c];
      if (c == int'(col_q)) begin
        open_up   = row_up[c];
        open_down = row_dn[c];
      end
    end

    moves_d = in_grid_q ? {open_left, open_down, open_up, open_right} : 4'b0000;
  end

  // NOTE: only the pipeline flops are reset; the maze is a constant ROM and
  // needs no reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_moves <= 4'b0000;
    else     valid_moves <= moves_d;
  end

endmodule

// File: tb/tb_valid_move_checker.sv
// -----------------------------------------------------------------------------
// tb_valid_move_checker
//
// Self-checking bench for valid_move_checker with the default bring-up maze
// (all path except walls at (col 8,row 7) and (col 1,row 24)). Expected values
// come from a reference model that works directly in pixel/cell arithmetic.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_valid_move_checker;

  localparam int ORG_X = 336;
  localparam int ORG_Y = 27;
  localparam int OFS   = 7;
  localparam int TILE  = 16;
  localparam int COLS  = 28;
  localparam int ROWS  = 31;

  logic        clk;
  logic        rst;
  logic [10:0] curr_pos_x;
  logic [9:0]  curr_pos_y;
  logic [3:0]  valid_moves;

  int errors;
  int checks;

  // Expected outputs for the inputs driven one and two cycles ago.
  logic [3:0] e1;
  logic [3:0] e2;

  valid_move_checker dut (
    .clk         (clk),
    .rst         (rst),
    .curr_pos_x  (curr_pos_x),
    .curr_pos_y  (curr_pos_y),
    .valid_moves (valid_moves)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic bit is_path(int r, int c);
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
    if (r == 7 && c == 8)  return 1'b0;
    if (r == 24 && c == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] ref_moves(int x, int y);
    int rx;
    int ry;
    int col;
    int row;
    rx = x - ORG_X - OFS;
    ry = y - ORG_Y - OFS;
    if (rx < 0 || ry < 0) return 4'b0000;
    col = rx / TILE;
    row = ry / TILE;
    if (col >= COLS || row >= ROWS) return 4'b0000;
`ifdef CENTER_ALIGN_EN
    if ((rx % TILE) != 0 || (ry % TILE) != 0) return 4'b0000;
`endif
    return {is_path(row, col - 1), is_path(row + 1, col),
            is_path(row - 1, col), is_path(row, col + 1)};
  endfunction

  // One cycle of streaming stimulus: check the output due now, then present
  // the next input. Called at a falling edge; returns at the next one.
  task automatic step(input int x, input int y, input string tag);
    check(tag, valid_moves, e2);
    e2 = e1;
    e1 = rst ? 4'b0000 : ref_moves(x, y);
    curr_pos_x = 11'(x);
    curr_pos_y = 10'(y);
    @(negedge clk);
  endtask

  // Hold one input for two clocks and compare against a literal expectation.
  task automatic directed(input int x, input int y, input logic [3:0] exp,
                          input string tag);
    curr_pos_x = 11'(x);
    curr_pos_y = 10'(y);
    @(negedge clk);
    @(negedge clk);
    check(tag, valid_moves, exp);
  endtask

  // Pixel anchor of a cell (exactly on its tile anchor).
  function automatic int ax(int c);
    return ORG_X + OFS + c * TILE;
  endfunction
  function automatic int ay(int r);
    return ORG_Y + OFS + r * TILE;
  endfunction

  initial begin
    int x;
    int y;
    errors = 0;
    checks = 0;
    e1 = 4'b0000;
    e2 = 4'b0000;
    rst = 1'b1;
    curr_pos_x = 11'd455;
    curr_pos_y = 10'd146;

    // Reset state, with a valid in-grid input present.
    repeat (3) @(negedge clk);
    check("reset_state", valid_moves, 4'b0000);
    rst = 1'b0;

    // Directed cases, including every border and wall situation.
    directed(455, 146, 4'b1110, "cell_7_7_right_wall");
    directed(487, 114, 4'b1111, "cell_9_5_open");
    directed(359, 434, 4'b1101, "cell_1_25_up_wall");
    directed(343, 34,  4'b0101, "cell_0_0_corner");
    directed(100, 34,  4'b0000, "left_of_grid");
    directed(ax(27), ay(0),  4'b1100, "cell_27_0_corner");
    directed(ax(0),  ay(30), 4'b0011, "cell_0_30_corner");
    directed(ax(27), ay(30), 4'b1010, "cell_27_30_corner");
    directed(ax(28), ay(5),  4'b0000, "col_past_grid");
    directed(ax(5),  ay(31), 4'b0000, "row_past_grid");
    directed(ax(9),  ay(7),  4'b0111, "cell_9_7_left_wall");
    directed(ax(8),  ay(6),  4'b1011, "cell_8_6_down_wall");
    directed(ax(5),  ay(0) - 1, 4'b0000, "one_px_above_grid");
`ifdef CENTER_ALIGN_EN
    directed(456, 146, 4'b0000, "off_centre_blocked");
    directed(455, 146, 4'b1110, "on_centre_allowed");
`else
    directed(456, 146, 4'b1110, "off_centre_floor");
    directed(ax(7) + 15, ay(7) + 15, 4'b1110, "off_centre_max");
`endif

    // Streaming: the held input makes both pipeline expectations equal.
    e1 = ref_moves(int'(curr_pos_x), int'(curr_pos_y));
    e2 = e1;

    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        // Mid-run reset with a known nonzero output.
        repeat (3) step(487, 114, "pre_reset");
        check("pre_reset_nonzero", valid_moves, 4'b1111);
        #2 rst = 1'b1;
        #1 check("reset_async", valid_moves, 4'b0000);
        e1 = 4'b0000;
        e2 = 4'b0000;
        @(negedge clk);
        repeat (3) step(487, 114, "reset_held");
        rst = 1'b0;
        // Output stays 0 for two clocks after release, then tracks again.
      end
      case ($urandom_range(0, 3))
        0: begin
          x = ax(int'($urandom_range(0, 29)) - 1);
          y = ay(int'($urandom_range(0, 32)) - 1);
        end
        1: begin
          x = int'($urandom_range(320, ORG_X + OFS + COLS * TILE + 16));
          y = int'($urandom_range(20, ORG_Y + OFS + ROWS * TILE + 16));
        end
        2: begin
          x = int'($urandom_range(0, 2047));
          y = int'($urandom_range(0, 1023));
        end
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            x = ax(int'($urandom_range(7, 9)));
            y = ay(int'($urandom_range(6, 8)));
          end else begin
            x = ax(int'($urandom_range(0, 2)));
            y = ay(int'($urandom_range(23, 25)));
          end
        end
      endcase
      step(x, y, "stream");
    end

    // Drain the pipeline.
    step(0, 0, "drain");
    step(0, 0, "drain");
    check("drain_final", valid_moves, e2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
